// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with a 2-entry skid buffer and synchronous flush.
// Latency 1 cycle; in_ready is registered and drops only when both entries are occupied.
module pipe_stage_buffer #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    CHANNELS     = 3,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0,
    parameter bit                    HOLD_DATA    = 1'b0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic [1:0]                     occupancy
);

    localparam int W = CHANNELS * DATA_WIDTH;
    localparam logic [W-1:0] BUBBLE_BUS = {CHANNELS{BUBBLE_VALUE}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_main;
    logic [W-1:0]   r_skid;
    logic [W-1:0]   w_main_nxt;
    logic [W-1:0]   w_skid_nxt;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [1:0]     r_occ;
    logic           w_accept;
    logic           w_consume;

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            if (!HOLD_DATA) w_main_nxt = BUBBLE_BUS;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        w_main_nxt = in_data;
                    end else if (w_accept) begin
                        w_state_nxt = ST_FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_consume) begin
                        w_state_nxt = ST_EMPTY;
                        if (!HOLD_DATA) w_main_nxt = BUBBLE_BUS;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so the only possible move is draining the skid entry
                    if (w_consume) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main      <= BUBBLE_BUS;
            r_skid      <= BUBBLE_BUS;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_occ       <= (w_state_nxt == ST_FULL) ? 2'd2 :
                           (w_state_nxt == ST_ONE)  ? 2'd1 : 2'd0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: three configurations share one stimulus stream and one FIFO reference model.
module tb_pipe_stage_buffer;

    logic         clock = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;

    logic         a_in_ready, a_out_valid;
    logic [95:0]  a_out_data;
    logic [1:0]   a_occ;
    logic         b_in_ready, b_out_valid;
    logic [31:0]  b_out_data;
    logic [1:0]   b_occ;
    logic         c_in_ready, c_out_valid;
    logic [127:0] c_out_data;
    logic [1:0]   c_occ;

    localparam logic [127:0] A_BUBBLE = {32'h0, {3{32'h0000_0013}}};
    localparam logic [127:0] B_BUBBLE = 128'h13;

    always #5 clock = ~clock;

    pipe_stage_buffer #(.DATA_WIDTH(32), .CHANNELS(3), .BUBBLE_VALUE(32'h0000_0013), .HOLD_DATA(1'b0)) u_a (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data[95:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .occupancy(a_occ));

    pipe_stage_buffer #(.DATA_WIDTH(32), .CHANNELS(1), .BUBBLE_VALUE(32'h0000_0013), .HOLD_DATA(1'b1)) u_b (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data[31:0]), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .occupancy(b_occ));

    pipe_stage_buffer #(.DATA_WIDTH(32), .CHANNELS(4), .BUBBLE_VALUE(32'h0), .HOLD_DATA(1'b0)) u_c (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_data(c_out_data), .occupancy(c_occ));

    int n_vec = 0;
    int n_err = 0;

    // Reference: an in-order queue of accepted words, capped at two entries.
    logic [127:0] q[$];
    logic [127:0] held;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        held = B_BUBBLE;
    endtask

    task automatic model_update();
        bit acc;
        bit con;
        if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            con = out_ready && (q.size() > 0);
            if (con) void'(q.pop_front());
            if (acc) q.push_back(in_data);
        end
        if (q.size() > 0) held = q[0];
    endtask

    task automatic check_all();
        logic [127:0] exp_a, exp_b, exp_c;
        int sz;
        sz = q.size();
        exp_a = (sz > 0) ? {32'h0, q[0][95:0]} : A_BUBBLE;
        exp_b = (sz > 0) ? {96'h0, q[0][31:0]} : {96'h0, held[31:0]};
        exp_c = (sz > 0) ? q[0] : 128'h0;
        check_eq("a_in_ready", 128'(a_in_ready), 128'(sz < 2));
        check_eq("a_out_valid", 128'(a_out_valid), 128'(sz > 0));
        check_eq("a_occupancy", 128'(a_occ), 128'(sz));
        check_eq("a_out_data", 128'(a_out_data), exp_a);
        check_eq("b_in_ready", 128'(b_in_ready), 128'(sz < 2));
        check_eq("b_out_valid", 128'(b_out_valid), 128'(sz > 0));
        check_eq("b_occupancy", 128'(b_occ), 128'(sz));
        check_eq("b_out_data", 128'(b_out_data), exp_b);
        check_eq("c_in_ready", 128'(c_in_ready), 128'(sz < 2));
        check_eq("c_out_valid", 128'(c_out_valid), 128'(sz > 0));
        check_eq("c_occupancy", 128'(c_occ), 128'(sz));
        check_eq("c_out_data", c_out_data, exp_c);
    endtask

    // Inputs are set at the falling edge before calling; outputs checked at the next falling edge.
    task automatic step();
        @(posedge clock);
        model_update();
        @(negedge clock);
        check_all();
    endtask

    initial begin
        int w;
        int exp_seq;
        bit acc;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_all();
        reset = 1'b0;

        // Single word pulse, then bubble
        in_valid = 1'b1; out_ready = 1'b1;
        in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        step();
        check_eq("t1_lanes", 128'(a_out_data), 128'({32'h33333333, 32'h22222222, 32'h11111111}));
        in_valid = 1'b0;
        step();
        check_eq("t1_bubble", 128'(a_out_data), A_BUBBLE);

        // Continuous stream at full throughput
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_data = {4{32'(i)}};
            step();
            check_eq("t2_word", 128'(a_out_data[31:0]), 128'(i));
            check_eq("t2_occ", 128'(a_occ), 128'd1);
        end
        in_valid = 1'b0;
        step();

        // Back-pressure: fill both entries, then drain in order
        out_ready = 1'b0; in_valid = 1'b1; w = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = {4{32'(w)}};
            acc = a_in_ready;
            step();
            if (acc) w++;
        end
        check_eq("t3_occ_full", 128'(a_occ), 128'd2);
        check_eq("t3_in_ready_low", 128'(a_in_ready), 128'd0);
        check_eq("t3_head", 128'(a_out_data[31:0]), 128'd1);
        out_ready = 1'b1; exp_seq = 1;
        for (int i = 0; i < 12; i++) begin
            in_valid = (w <= 4);
            in_data = {4{32'(w)}};
            acc = a_in_ready && in_valid;
            if (a_out_valid) begin
                check_eq("t3_order", 128'(a_out_data[31:0]), 128'(exp_seq));
                exp_seq++;
            end
            step();
            if (acc) w++;
        end
        check_eq("t3_count", 128'(exp_seq), 128'd5);

        // Flush from FULL with a word offered and downstream ready
        in_valid = 1'b1; out_ready = 1'b0;
        in_data = {4{32'hAAAA_0001}}; step();
        in_data = {4{32'hBBBB_0002}}; step();
        check_eq("t4_pre_occ", 128'(a_occ), 128'd2);
        flush = 1'b1; out_ready = 1'b1; in_data = {4{32'hCCCC_0003}};
        step();
        check_eq("t4_occ", 128'(a_occ), 128'd0);
        check_eq("t4_out_valid", 128'(a_out_valid), 128'd0);
        check_eq("t4_in_ready", 128'(a_in_ready), 128'd1);
        check_eq("t4_bubble", 128'(a_out_data), A_BUBBLE);
        check_eq("t4_hold", 128'(b_out_data), 128'h0000_0000_0000_0000_0000_0000_AAAA_0001);
        flush = 1'b0; in_valid = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
            if (a_occ > 2'd2) check_eq("occ_bound", 128'(a_occ), 128'd2);
        end
        flush = 1'b0;

        // Asynchronous reset between edges while FULL
        in_valid = 1'b1; out_ready = 1'b0;
        in_data = {4{32'h1234_0001}}; step();
        in_data = {4{32'h1234_0002}}; step();
        check_eq("t6_pre_occ", 128'(a_occ), 128'd2);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check_eq("t6_async_data", 128'(a_out_data), A_BUBBLE);
        @(negedge clock);
        reset = 1'b0;

        // Held output after the single word is consumed
        in_valid = 1'b1; out_ready = 1'b0; in_data = {4{32'h5A5A_C3C3}};
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check_eq("t6_b_valid", 128'(b_out_valid), 128'd0);
        check_eq("t6_b_hold", 128'(b_out_data), 128'h5A5A_C3C3);
        step();
        check_eq("t6_b_hold2", 128'(b_out_data), 128'h5A5A_C3C3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
- Parametrised successor to the processor's fixed inter-stage register: carries CHANNELS lanes of DATA_WIDTH bits between two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure from the downstream stage never drops or duplicates a word.
- Adds a synchronous flush that injects bubbles.
- Used between all pipeline stages (e.g. MEM/WB carrying data, memory data and instruction lanes).

Parameters:
- DATA_WIDTH, 32, width of each lane.
- CHANNELS, 3, number of lanes; the data bus is CHANNELS*DATA_WIDTH bits, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- BUBBLE_VALUE, 0, DATA_WIDTH-bit value driven on every lane when no valid word is presented (e.g. NOP encoding).
- HOLD_DATA, 0, controls out_data while out_valid=0: 1 = hold the last presented word; 0 = drive BUBBLE_VALUE on all lanes.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all buffered words.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  buffer can accept a word this cycle; registered.
- in_data  input  CHANNELS*DATA_WIDTH  upstream lanes.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  CHANNELS*DATA_WIDTH  registered output lanes.
- occupancy  output  2  number of buffered words: 0, 1 or 2.

Behaviour:
- Storage: main register, which drives out_data, plus one skid register. All outputs are driven from flops; no combinational path from in_* to out_*, and none from out_ready to in_ready.
- Transfers:
  - Accept: in_valid && in_ready at the clock edge.
  - Consume: out_valid && out_ready at the clock edge.
- States:
  - EMPTY (occupancy 0).
  - ONE (main valid).
  - FULL (main and skid valid).
- Transitions (no flush):
  - EMPTY + accept -> ONE; main <= in_data.
  - ONE + accept, no consume -> FULL; skid <= in_data.
  - ONE + consume, no accept -> EMPTY.
  - ONE + accept + consume -> ONE; main <= in_data (single-cycle throughput, latency 1).
  - FULL + consume -> ONE; main <= skid. No accept is possible in FULL because in_ready=0.
  - Any other combination -> hold.
- in_ready:
  - Registered.
  - Equals 1 in EMPTY and ONE, 0 in FULL.
  - It becomes 0 the cycle after a ONE -> FULL transition and returns to 1 the cycle after FULL -> ONE.
- Word ordering: strictly FIFO. No word is lost or duplicated under any out_ready pattern.
- Latency: a word accepted at edge N appears on out_data with out_valid=1 after edge N, when the buffer was EMPTY, or when it was ONE and consumed at that same edge.
- Flush:
  - Highest priority over accept and consume in the same cycle.
  - Next state is EMPTY, in_ready=1, occupancy=0.
  - A word offered during the flush cycle is not accepted, even though in_ready=1.
  - out_data goes to BUBBLE_VALUE on all lanes when HOLD_DATA=0, and is held when HOLD_DATA=1.
- Out-of-protocol behaviour: out_ready while out_valid=0 has no effect. in_valid while in_ready=0 is ignored, and in_data is not sampled.
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - out_valid=0, in_ready=1, occupancy=0.
  - out_data and the skid register are set to BUBBLE_VALUE on all lanes, regardless of HOLD_DATA.
  - The first edge after reset deasserts behaves as EMPTY.
- Lanes are independent copies with no arithmetic. CHANNELS=1 must elaborate. The skid register is only ever written from in_data.

Test Plan:
- Reset, then pulse in_valid for one cycle with lanes {0x11111111, 0x22222222, 0x33333333}, out_ready=1 -> the next cycle out_valid=1 with the same lanes. The following cycle out_valid=0 and lanes=BUBBLE_VALUE (HOLD_DATA=0).
- Continuous stream 1..8 with in_valid=1 and out_ready=1 -> one word per cycle, in order, in_ready stays 1, occupancy stays 1.
- Stream 1..4 with out_ready held 0 -> words 1 and 2 buffered, occupancy=2, in_ready=0 from the cycle after word 2, words 3 and 4 held upstream. Release out_ready -> output sequence 1, 2, 3, 4 with no gaps or duplicates.
- FULL with words A and B, assert flush together with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, the offered word is absent, and lanes equal BUBBLE_VALUE (0x00000013 when BUBBLE_VALUE=0x00000013).
- Random in_valid/out_ready, 10,000 cycles, CHANNELS=1 and CHANNELS=4 -> the scoreboard matches an in-order FIFO, and occupancy never exceeds 2.
- Assert reset asynchronously between edges while FULL -> out_valid=0, in_ready=1 and occupancy=0 immediately, before the next edge, with lanes equal to BUBBLE_VALUE. With HOLD_DATA=1 after reset, consume one word -> the lanes hold it while out_valid=0.
